// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the two-port arbitrated adder: datapath width,
// port count, operation encoding and the registered result record.
package adder_arbiter_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned NUM_PORTS = 2;
  localparam int unsigned CNT_W     = 16;

  // Operation select as presented on reqN_sub.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Identity of a requester; also the encoding of the last-grant pointer.
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  // One held result.
  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              cout;
    logic              ovf;
  } result_t;

  // Operand B as seen by the adder: inverted for subtract (A + ~B + 1).
  function automatic logic [DATA_W-1:0] effective_b(
    input logic [DATA_W-1:0] b,
    input op_e               op
  );
    return (op == OP_SUB) ? ~b : b;
  endfunction

endpackage

// File: rtl/adder_arbiter_cla.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups whose group
// generate/propagate terms feed the inter-group carry chain. Reports the
// carry out of bit 31 and two's-complement overflow of the operands given.
module cla_adder_32bit
  import adder_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout,
  output logic              ovf
);

  localparam int unsigned GROUPS = DATA_W / 4;

  logic [DATA_W-1:0] g;
  logic [DATA_W-1:0] p;
  logic [GROUPS-1:0] gg;
  logic [GROUPS-1:0] gp;
  logic [DATA_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Per-group generate/propagate, independent of any incoming carry.
  for (genvar k = 0; k < GROUPS; k++) begin : g_grp
    localparam int unsigned B = 4 * k;
    assign gg[k] = g[B+3]
                 | (p[B+3] & g[B+2])
                 | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign gp[k] = &p[B+3:B];
  end

  // Carries: group boundaries from gg/gp, in-group carries fully expanded.
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int unsigned k = 0; k < GROUPS; k++) begin
      c[4*k+1] = g[4*k]
               | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1]
               | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+3] = g[4*k+2]
               | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
    end
  end

  assign sum  = p ^ c[DATA_W-1:0];
  assign cout = c[DATA_W];
  assign ovf  = c[DATA_W] ^ c[DATA_W-1];

endmodule

// File: rtl/adder_arbiter.sv
// Two requesters share one 32-bit add/subtract unit. Each cycle at most one
// eligible requester is granted (round-robin or fixed priority), its result
// lands in that port's response register one cycle later, and every accepted
// operation bumps a wrapping 16-bit counter.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned FAIR_RR = 1
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_sub,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_sub,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_sum,
  output logic              rsp0_cout,
  output logic              rsp0_ovf,

  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_sum,
  output logic              rsp1_cout,
  output logic              rsp1_ovf,

  output logic [CNT_W-1:0]  ops_done
);

  logic              elig0;
  logic              elig1;
  logic              gnt0;
  logic              gnt1;
  logic              accept;
  port_e             last_grant;

  op_e               op_sel;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_cin;
  result_t           add_res;
  result_t           res0;
  result_t           res1;

  // A port may go when it has work and its response slot is free or draining.
  assign elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
  assign elig1 = req1_valid & (~rsp1_valid | rsp1_ready);

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (elig0 && elig1) begin
        if ((FAIR_RR != 0) && (last_grant == PORT0)) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
      end else begin
        gnt0 = elig0;
        gnt1 = elig1;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign accept     = gnt0 | gnt1;

  // Steer the granted port's operands into the shared adder.
  always_comb begin
    if (gnt1) begin
      op_a   = req1_a;
      op_sel = op_e'(req1_sub);
      op_b   = effective_b(req1_b, op_e'(req1_sub));
    end else begin
      op_a   = req0_a;
      op_sel = op_e'(req0_sub);
      op_b   = effective_b(req0_b, op_e'(req0_sub));
    end
    op_cin = (op_sel == OP_SUB);
  end

  cla_adder_32bit u_adder (
    .a    (op_a),
    .b    (op_b),
    .cin  (op_cin),
    .sum  (add_res.sum),
    .cout (add_res.cout),
    .ovf  (add_res.ovf)
  );

  // Port 0 response register: load on grant, otherwise clear on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      res0       <= '0;
    end else if (gnt0) begin
      rsp0_valid <= 1'b1;
      res0       <= add_res;
    end else if (rsp0_ready) begin
      rsp0_valid <= 1'b0;
    end
  end

  // Port 1 response register: load on grant, otherwise clear on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp1_valid <= 1'b0;
      res1       <= '0;
    end else if (gnt1) begin
      rsp1_valid <= 1'b1;
      res1       <= add_res;
    end else if (rsp1_ready) begin
      rsp1_valid <= 1'b0;
    end
  end

  // Last-grant pointer and accept counter move only on a grant; the pointer
  // resets to port 1 so port 0 takes the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PORT1;
      ops_done   <= '0;
    end else if (accept) begin
      last_grant <= gnt1 ? PORT1 : PORT0;
      ops_done   <= ops_done + 1'b1;
    end
  end

  assign rsp0_sum  = res0.sum;
  assign rsp0_cout = res0.cout;
  assign rsp0_ovf  = res0.ovf;
  assign rsp1_sum  = res1.sum;
  assign rsp1_cout = res1.cout;
  assign rsp1_ovf  = res1.ovf;

endmodule
